// File: rtl/lsu_mem_stage.sv
// Load/store unit memory stage: aligns and issues one data-memory access at a time over req/gnt/rvalid,
// then returns extended load data to writeback or flags misaligned/illegal accesses.
module lsu_mem_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              load_sel_i,
    input  logic              store_sel_i,
    input  logic [2:0]        load_op_i,
    input  logic [2:0]        store_op_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [4:0]        rd_addr_i,
    output logic              data_req_o,
    output logic              data_we_o,
    output logic [3:0]        data_be_o,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic [DATA_W-1:0] data_wdata_o,
    input  logic              data_gnt_i,
    input  logic              data_rvalid_i,
    input  logic [DATA_W-1:0] data_rdata_i,
    output logic              wb_valid_o,
    output logic [4:0]        wb_rd_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] err_addr_o
);

    typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID} state_t;

    state_t state, state_nxt;

    // op[1:0] encodes access size for both loads and stores: 0=byte, 1=half, 2=word
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] store_align(input logic [1:0] size,
                                                       input logic [DATA_W-1:0] w);
        case (size)
            2'b00:   return {4{w[7:0]}};
            2'b01:   return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] load_extend(input logic [2:0] op,
                                                       input logic [1:0] off,
                                                       input logic [DATA_W-1:0] rdata);
        logic [DATA_W-1:0]        sh;
        logic signed [7:0]        b_s;
        logic signed [15:0]       h_s;
        logic signed [DATA_W-1:0] r;
        sh  = rdata >> {off, 3'b000};
        b_s = sh[7:0];
        h_s = sh[15:0];
        case (op)
            3'b000:  r = DATA_W'(b_s);
            3'b001:  r = DATA_W'(h_s);
            3'b100:  r = $signed(DATA_W'(sh[7:0]));
            3'b101:  r = $signed(DATA_W'(sh[15:0]));
            default: r = $signed(sh);
        endcase
        return r;
    endfunction

    logic [2:0] op_in;
    logic       accept, bad_op, misalign, illegal;

    assign op_in    = load_sel_i ? load_op_i : store_op_i;
    assign accept   = (state == IDLE) && valid_i && (load_sel_i || store_sel_i);
    assign bad_op   = load_sel_i ? ((op_in == 3'b011) || (op_in[2:1] == 2'b11))
                                 : (op_in[2] || (op_in[1:0] == 2'b11));
    assign misalign = ((op_in[1:0] == 2'b01) && addr_i[0])
                   || ((op_in[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
    assign illegal  = (load_sel_i && store_sel_i) || bad_op || misalign;

    // Stage p1: captured access
    logic              we_p1;
    logic [2:0]        op_p1;
    logic [3:0]        be_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [DATA_W-1:0] wdata_p1;
    logic [4:0]        rd_p1;

    // Stage p2: completion pulses and writeback results
    logic              vld_p2, done_p2, err_p2;
    logic [4:0]        wb_rd_p2;
    logic [DATA_W-1:0] wb_data_p2;
    logic [ADDR_W-1:0] err_addr_p2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:        if (accept && !illegal) state_nxt = WAIT_GNT;
            WAIT_GNT:    if (data_gnt_i) state_nxt = we_p1 ? IDLE : WAIT_RVALID;
            WAIT_RVALID: if (data_rvalid_i) state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_p1       <= 1'b0;
            op_p1       <= '0;
            be_p1       <= '0;
            addr_p1     <= '0;
            wdata_p1    <= '0;
            rd_p1       <= '0;
            vld_p2      <= 1'b0;
            done_p2     <= 1'b0;
            err_p2      <= 1'b0;
            wb_rd_p2    <= '0;
            wb_data_p2  <= '0;
            err_addr_p2 <= '0;
        end else begin
            if (accept && !illegal) begin
                we_p1    <= store_sel_i;
                op_p1    <= op_in;
                be_p1    <= byte_en(op_in[1:0], addr_i[1:0]);
                addr_p1  <= addr_i;
                wdata_p1 <= store_align(op_in[1:0], wdata_i);
                rd_p1    <= rd_addr_i;
            end
            err_p2  <= accept && illegal;
            if (accept && illegal) err_addr_p2 <= addr_i;
            vld_p2  <= (state == WAIT_RVALID) && data_rvalid_i;
            done_p2 <= ((state == WAIT_GNT) && data_gnt_i && we_p1)
                    || ((state == WAIT_RVALID) && data_rvalid_i);
            if ((state == WAIT_RVALID) && data_rvalid_i) begin
                wb_rd_p2   <= rd_p1;
                wb_data_p2 <= load_extend(op_p1, addr_p1[1:0], data_rdata_i);
            end
        end
    end

    assign ready_o      = (state == IDLE);
    assign data_req_o   = (state == WAIT_GNT);
    assign data_we_o    = data_req_o && we_p1;
    assign data_be_o    = data_req_o ? be_p1 : 4'b0000;
    assign data_addr_o  = data_req_o ? {addr_p1[ADDR_W-1:2], 2'b00} : '0;
    assign data_wdata_o = data_req_o ? wdata_p1 : '0;
    assign wb_valid_o   = vld_p2;
    assign wb_rd_o      = wb_rd_p2;
    assign wb_data_o    = wb_data_p2;
    assign done_o       = done_p2;
    assign err_o        = err_p2;
    assign err_addr_o   = err_addr_p2;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage: byte-addressed memory model predicts requests and completions,
// a responder emulates the data memory, and a monitor compares everything the DUT presents.
module tb_lsu_mem_stage;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              valid_i, ready_o, load_sel_i, store_sel_i;
    logic [2:0]        load_op_i, store_op_i;
    logic [ADDR_W-1:0] addr_i;
    logic [DATA_W-1:0] wdata_i;
    logic [4:0]        rd_addr_i;
    logic              data_req_o, data_we_o;
    logic [3:0]        data_be_o;
    logic [ADDR_W-1:0] data_addr_o;
    logic [DATA_W-1:0] data_wdata_o;
    logic              data_gnt_i, data_rvalid_i;
    logic [DATA_W-1:0] data_rdata_i;
    logic              wb_valid_o, done_o, err_o;
    logic [4:0]        wb_rd_o;
    logic [DATA_W-1:0] wb_data_o;
    logic [ADDR_W-1:0] err_addr_o;

    lsu_mem_stage #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
        .load_sel_i(load_sel_i), .store_sel_i(store_sel_i),
        .load_op_i(load_op_i), .store_op_i(store_op_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .rd_addr_i(rd_addr_i),
        .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
        .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
        .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
        .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
        .done_o(done_o), .err_o(err_o), .err_addr_o(err_addr_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;
    typedef enum int {EV_DONE, EV_LOAD, EV_ERR} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [4:0]  rd;
        logic [31:0] data;
    } ev_t;

    req_t        req_q[$];
    ev_t         ev_q[$];
    logic [7:0]  model_mem [1024];
    logic [31:0] ram [256];
    int          checks = 0;
    int          passes = 0;
    int          fixed_gnt = -1;
    int          fixed_rv = -1;
    int          gnt_wait = 0;
    int          rv_wait = 0;
    bit          in_req = 0;
    logic [7:0]  rv_idx = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic set_word(input logic [31:0] a, input logic [31:0] v);
        ram[a[9:2]] = v;
        for (int i = 0; i < 4; i++) model_mem[{a[9:2], 2'b00} + 10'(i)] = v[8*i +: 8];
    endtask

    // Reference model: byte-addressed memory with RISC-V load/store semantics
    task automatic model_issue(input logic ld, input logic st, input logic [2:0] op,
                               input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
        int   n;
        bit   legal;
        req_t r;
        ev_t  e;
        logic [31:0] v;
        if (!ld && !st) return;
        n = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
        legal = !(ld && st);
        if (ld && !(op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) legal = 0;
        if (st && !(op inside {3'd0, 3'd1, 3'd2})) legal = 0;
        if ((int'(a[1:0]) % n) != 0) legal = 0;
        if (!legal) begin
            e.kind = EV_ERR; e.rd = '0; e.data = a;
            ev_q.push_back(e);
            return;
        end
        r.we = st; r.addr = a & ~32'h3; r.be = '0; r.wdata = '0;
        for (int i = 0; i < n; i++) r.be[int'(a[1:0]) + i] = 1'b1;
        if (st) begin
            for (int k = 0; k < 4; k++) r.wdata[8*k +: 8] = wd[8*(k % n) +: 8];
            for (int i = 0; i < n; i++) model_mem[a[9:0] + 10'(i)] = wd[8*i +: 8];
            e.kind = EV_DONE; e.rd = '0; e.data = '0;
        end else begin
            v = '0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = model_mem[a[9:0] + 10'(i)];
            if (!op[2] && n < 4 && v[8*n-1]) v = v - (32'd1 << (8*n));
            e.kind = EV_LOAD; e.rd = rd; e.data = v;
        end
        req_q.push_back(r);
        ev_q.push_back(e);
    endtask

    task automatic issue(input logic ld, input logic st, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
        int n = 0;
        while (!ready_o && n < 200) begin @(negedge clk); n++; end
        if (!ready_o) chk("issue_ready_timeout", 32'(ready_o), 32'd1);
        model_issue(ld, st, op, a, wd, rd);
        valid_i = 1'b1; load_sel_i = ld; store_sel_i = st;
        load_op_i = op; store_op_i = op; addr_i = a; wdata_i = wd; rd_addr_i = rd;
        @(negedge clk);
        valid_i = 1'b0; load_sel_i = 1'b0; store_sel_i = 1'b0;
        addr_i = $urandom; wdata_i = $urandom;
    endtask

    task automatic wait_wb(input string name, input logic [31:0] exp);
        int n = 0;
        while (!wb_valid_o && n < 50) begin @(negedge clk); n++; end
        chk({name, "_vld"}, 32'(wb_valid_o), 32'd1);
        chk({name, "_data"}, wb_data_o, exp);
    endtask

    // Memory responder: byte-lane RAM driven by the DUT's own be/wdata
    initial begin
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0;
        forever begin
            @(negedge clk);
            data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = $urandom;
            if (rst) in_req = 0;
            if (rv_wait > 0) begin
                rv_wait--;
                if (rv_wait == 0) begin
                    data_rvalid_i = 1'b1;
                    data_rdata_i  = ram[rv_idx];
                end
            end else if (data_req_o && !rst) begin
                if (!in_req) begin
                    in_req = 1;
                    gnt_wait = (fixed_gnt < 0) ? int'($urandom_range(0, 3)) : fixed_gnt;
                end
                if (gnt_wait == 0) begin
                    data_gnt_i = 1'b1;
                    in_req = 0;
                    if (data_we_o) begin
                        for (int k = 0; k < 4; k++)
                            if (data_be_o[k]) ram[data_addr_o[9:2]][8*k +: 8] = data_wdata_o[8*k +: 8];
                    end else begin
                        rv_idx  = data_addr_o[9:2];
                        rv_wait = (fixed_rv < 0) ? int'($urandom_range(1, 3)) : fixed_rv;
                    end
                end else begin
                    gnt_wait--;
                end
            end
        end
    end

    // Monitor: compares requests and completion pulses against the scoreboard queues
    initial begin
        req_t cur;
        ev_t  e;
        bit   active = 0;
        bit   cur_ok = 0;
        forever begin
            @(negedge clk);
            if (data_req_o) begin
                if (!active) begin
                    active = 1;
                    if (req_q.size() == 0) begin
                        cur_ok = 0;
                        chk("unexpected_req", 32'(data_req_o), 32'd0);
                    end else begin
                        cur = req_q.pop_front();
                        cur_ok = 1;
                        chk("req_we", 32'(data_we_o), 32'(cur.we));
                        chk("req_be", 32'(data_be_o), 32'(cur.be));
                        chk("req_addr", data_addr_o, cur.addr);
                        if (cur.we) chk("req_wdata", data_wdata_o, cur.wdata);
                    end
                end else if (cur_ok) begin
                    chk("req_hold_we", 32'(data_we_o), 32'(cur.we));
                    chk("req_hold_be", 32'(data_be_o), 32'(cur.be));
                    chk("req_hold_addr", data_addr_o, cur.addr);
                    if (cur.we) chk("req_hold_wdata", data_wdata_o, cur.wdata);
                end
            end else begin
                active = 0;
            end
            if (done_o || wb_valid_o || err_o) begin
                if (ev_q.size() == 0) begin
                    chk("unexpected_event", 32'({done_o, wb_valid_o, err_o}), 32'd0);
                end else begin
                    e = ev_q.pop_front();
                    case (e.kind)
                        EV_ERR: begin
                            chk("err_flags", 32'({done_o, wb_valid_o, err_o}), 32'b001);
                            chk("err_addr", err_addr_o, e.data);
                        end
                        EV_DONE: chk("store_flags", 32'({done_o, wb_valid_o, err_o}), 32'b100);
                        default: begin
                            chk("load_flags", 32'({done_o, wb_valid_o, err_o}), 32'b110);
                            chk("load_rd", 32'(wb_rd_o), 32'(e.rd));
                            chk("load_data", wb_data_o, e.data);
                        end
                    endcase
                end
            end
        end
    end

    initial begin
        int cnt;
        logic [2:0]  op;
        logic [31:0] a;
        logic        ld, st;
        int          r;
        valid_i = 1'b0; load_sel_i = 1'b0; store_sel_i = 1'b0;
        load_op_i = '0; store_op_i = '0; addr_i = '0; wdata_i = '0; rd_addr_i = '0;
        for (int i = 0; i < 256; i++) set_word(32'(i * 4), $urandom);
        repeat (3) @(negedge clk);
        chk("rst_ready_in_reset", 32'(ready_o), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_ctrl", 32'({data_req_o, data_we_o, done_o, wb_valid_o, err_o}), 32'd0);
        chk("rst_be", 32'(data_be_o), 32'd0);
        chk("rst_addr", data_addr_o, 32'd0);
        chk("rst_wb_data", wb_data_o, 32'd0);
        chk("rst_err_addr", err_addr_o, 32'd0);

        // SW with a two-cycle grant stall
        fixed_gnt = 2; fixed_rv = 1;
        issue(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0);
        cnt = 0;
        while (data_req_o && cnt < 20) begin cnt++; @(negedge clk); end
        chk("sw_req_cycles", 32'(cnt), 32'd3);
        chk("sw_done", 32'(done_o), 32'd1);

        fixed_gnt = 0;
        set_word(32'h200, 32'h80FF1234);
        issue(1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 5'd7);
        chk("lb_be", 32'(data_be_o), 32'b1000);
        chk("lb_addr", data_addr_o, 32'h200);
        wait_wb("lb", 32'hFFFFFF80);
        issue(1'b1, 1'b0, 3'b101, 32'h202, 32'h0, 5'd8);
        chk("lhu_be", 32'(data_be_o), 32'b1100);
        wait_wb("lhu", 32'h000080FF);
        issue(1'b1, 1'b0, 3'b001, 32'h202, 32'h0, 5'd9);
        wait_wb("lh", 32'hFFFF80FF);

        issue(1'b0, 1'b1, 3'b001, 32'h306, 32'h0000ABCD, 5'd0);
        chk("sh_addr", data_addr_o, 32'h304);
        chk("sh_be", 32'(data_be_o), 32'b1100);
        chk("sh_wdata", data_wdata_o, 32'hABCDABCD);

        issue(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 5'd3);
        chk("lw_mis_err", 32'(err_o), 32'd1);
        chk("lw_mis_addr", err_addr_o, 32'h102);
        chk("lw_mis_ready", 32'(ready_o), 32'd1);
        chk("lw_mis_noreq", 32'(data_req_o), 32'd0);
        issue(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 5'd3);
        chk("ld_op011_err", 32'(err_o), 32'd1);
        chk("ld_op011_addr", err_addr_o, 32'h100);

        // Reset while waiting for read data; the late rvalid must be ignored
        fixed_rv = 5;
        issue(1'b1, 1'b0, 3'b010, 32'h040, 32'h0, 5'd4);
        cnt = 0;
        while (!(!data_req_o && !ready_o) && cnt < 20) begin @(negedge clk); cnt++; end
        chk("rstmid_in_wait_rvalid", 32'({data_req_o, ready_o}), 32'b00);
        rst = 1'b1;
        ev_q.delete();
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_ready", 32'(ready_o), 32'd1);
        chk("rstmid_ctrl", 32'({data_req_o, data_we_o, done_o, wb_valid_o, err_o}), 32'd0);
        chk("rstmid_wb_data", wb_data_o, 32'd0);
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (wb_valid_o || done_o || err_o) cnt++;
        end
        chk("rstmid_no_pulse", 32'(cnt), 32'd0);

        // Back-to-back: LW accepted on the SB done cycle
        fixed_gnt = -1; fixed_rv = -1;
        issue(1'b0, 1'b1, 3'b000, 32'h011, $urandom, 5'd0);
        cnt = 0;
        while (!ready_o && cnt < 50) begin @(negedge clk); cnt++; end
        chk("b2b_done_cycle", 32'(done_o), 32'd1);
        issue(1'b1, 1'b0, 3'b010, 32'h010, 32'h0, 5'd9);

        for (int t = 0; t < 300; t++) begin
            r = int'($urandom_range(0, 19));
            ld = (r == 0) || (r >= 2 && r < 11);
            st = (r == 0) || (r >= 11);
            if ($urandom_range(0, 9) < 8) begin
                if (ld && !st) begin
                    case ($urandom_range(0, 4))
                        0: op = 3'd0; 1: op = 3'd1; 2: op = 3'd2; 3: op = 3'd4; default: op = 3'd5;
                    endcase
                end else begin
                    op = 3'($urandom_range(0, 2));
                end
            end else begin
                op = 3'($urandom_range(0, 7));
            end
            a = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (op[1:0] == 2'd1) a[0] = 1'b0;
                else if (op[1:0] != 2'd0) a[1:0] = 2'b00;
            end
            issue(ld, st, op, a, $urandom, 5'($urandom));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        cnt = 0;
        while ((req_q.size() != 0 || ev_q.size() != 0) && cnt < 500) begin @(negedge clk); cnt++; end
        repeat (4) @(negedge clk);
        chk("drain_req_q", 32'(req_q.size()), 32'd0);
        chk("drain_ev_q", 32'(ev_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
Load/store unit directly downstream of the decoder. Consumes decoded control (load_sel/store_sel, load_op/store_op, rd address) plus the ALU-computed effective address and store data, and drives a req/gnt/rvalid data-memory port. Performs byte-lane alignment, byte-enable generation, load extraction and sign/zero extension, and misalignment detection. Returns load results to writeback. One outstanding access at a time.

Parameters:
ADDR_W, 32, effective/memory address width
DATA_W, 32, data width (fixed 32; byte-enable width DATA_W/8)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
valid_i  in  1  ctrl/operands valid this cycle
ready_o  out  1  LSU can accept (state IDLE)
load_sel_i  in  1  instruction is a load
store_sel_i  in  1  instruction is a store
load_op_i  in  3  LB=000 LH=001 LW=010 LBU=100 LHU=101
store_op_i  in  3  SB=000 SH=001 SW=010
addr_i  in  ADDR_W  effective byte address
wdata_i  in  DATA_W  rs2 store data
rd_addr_i  in  5  load destination register
data_req_o  out  1  memory request
data_we_o  out  1  1=write
data_be_o  out  4  byte enables
data_addr_o  out  ADDR_W  word-aligned address (addr[1:0]=00)
data_wdata_o  out  DATA_W  lane-aligned store data
data_gnt_i  in  1  request accepted
data_rvalid_i  in  1  read data valid
data_rdata_i  in  DATA_W  read data
wb_valid_o  out  1  one-cycle pulse, load result valid
wb_rd_o  out  5  load destination
wb_data_o  out  DATA_W  extended load result
done_o  out  1  one-cycle pulse, access complete (load or store)
err_o  out  1  one-cycle pulse, misaligned/illegal access
err_addr_o  out  ADDR_W  faulting address

Behaviour:
- Reset: state IDLE; all outputs 0 except ready_o=1; captured registers cleared. Reset mid-access drops the access; no wb/done/err afterwards.
- States: IDLE, WAIT_GNT, WAIT_RVALID.
- Accept: IDLE and valid_i and (load_sel_i or store_sel_i). Capture op, addr, wdata, rd. valid_i with neither select: ignored.
- Checks at accept (combinational on inputs): both selects set, unsupported funct3 (load 011/110/111, store 011..111), halfword with addr[0]=1, word with addr[1:0]!=00 -> no memory request; next cycle err_o=1, err_addr_o=addr_i; stay IDLE.
- Legal accept -> WAIT_GNT. In WAIT_GNT: data_req_o=1 with we/be/addr/wdata from registers, held stable until data_gnt_i. No request in the accept cycle (1-cycle min latency to req).
- gnt on store: next cycle done_o=1, -> IDLE. gnt on load: -> WAIT_RVALID, data_req_o deasserts next cycle.
- WAIT_RVALID: on data_rvalid_i, next cycle wb_valid_o=done_o=1, wb_rd_o, wb_data_o registered; -> IDLE. data_rvalid_i in any other state ignored; memory must return rvalid at least one cycle after gnt.
- ready_o=1 only in IDLE (incl. the cycle a done/err pulse is shown); back-to-back accept allowed on that cycle.
- Byte enables: SB/LB/LBU 0001<<a[1:0]; SH/LH/LHU 0011<<a[1:0]; SW/LW 1111. Loads drive be too; we=0.
- Store data: SB replicates wdata[7:0] to all 4 lanes; SH replicates wdata[15:0] to both halves; SW passes through.
- Load extract: shift rdata right by 8*a[1:0]; LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW as-is.
- wb_data_o/wb_rd_o hold last value when wb_valid_o=0; err_addr_o holds last fault.

Test Plan:
- SW addr 0x100 wdata 0xDEADBEEF, gnt after 2 wait cycles -> req held 3 cycles, be=1111, addr=0x100, we=1; done_o pulse cycle after gnt; no wb_valid_o.
- LB addr 0x203, rdata 0x80FF1234 (rvalid 1 cycle after gnt) -> be=1000, addr=0x200; wb_data_o=0xFFFFFF80, wb_valid_o one cycle.
- LHU addr 0x202, rdata 0x80FF1234 -> be=1100, wb_data_o=0x000080FF; LH same -> 0xFFFF80FF.
- SH addr 0x306 wdata 0x0000ABCD -> addr=0x304, be=1100, wdata=0xABCDABCD.
- LW addr 0x102 -> no data_req_o, err_o pulse, err_addr_o=0x102, ready_o stays 1; load_op=011 at aligned addr -> same err.
- Load accepted, rst asserted in WAIT_RVALID then rvalid arrives -> all outputs 0, ready_o=1, no wb_valid_o; back-to-back SB then LW accepted on done cycle -> both complete in order.
